// File: rtl/wide_compare_seq.sv
// wide_compare_seq: multi-cycle magnitude comparator for wide operands.
// Feeds operands one BIT_COUNT-wide slice per cycle (most-significant first)
// through a single xor_comparator. The first unequal slice decides the
// result, and later slices cannot change it.
//
// Ports (W = BIT_COUNT*SLICES):
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready request handshake; a, b, is_signed sampled on accept
//   out_valid/out_ready result handshake; result held until consumed
//   eq, gt, lt        registered compare flags (exactly one set in DONE)
//   xor_result        registered raw a ^ b
//
// xor_comparator: combinational single-slice compare.
//   a_i, b_i          slice operands
//   equal_o           a_i == b_i
//   a_larger_o        a_i > b_i (unsigned)
//   xor_result_o      a_i ^ b_i

module xor_comparator #(
   parameter int unsigned BIT_COUNT = 8
) (
   input  logic [BIT_COUNT-1:0] a_i,
   input  logic [BIT_COUNT-1:0] b_i,
   output logic                 equal_o,
   output logic                 a_larger_o,
   output logic [BIT_COUNT-1:0] xor_result_o
);

   assign xor_result_o = a_i ^ b_i;
   assign equal_o      = (xor_result_o == '0);
   assign a_larger_o   = (a_i > b_i);

endmodule

module wide_compare_seq #(
   parameter int unsigned BIT_COUNT = 8,
   parameter int unsigned SLICES    = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [BIT_COUNT*SLICES-1:0] a,
   input  logic [BIT_COUNT*SLICES-1:0] b,
   input  logic                        is_signed,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        eq,
   output logic                        gt,
   output logic                        lt,
   output logic [BIT_COUNT*SLICES-1:0] xor_result
);

   localparam int unsigned W  = BIT_COUNT * SLICES;
   localparam int unsigned KW = (SLICES > 1) ? $clog2(SLICES) : 1;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   state_e          state_q;
   logic [W-1:0]    a_q, b_q;
   logic            signed_q;
   logic [KW-1:0]   k_q;
   logic            decided_q, gt_r_q;
   logic            eq_q, gt_q, lt_q;
   logic [W-1:0]    xor_q;

   logic [BIT_COUNT-1:0] slice_a, slice_b, cmp_xor;
   logic                 cmp_equal, cmp_a_larger;
   logic                 top_slice;
   logic                 decided_nx, gt_nx;

   assign top_slice = (k_q == KW'(SLICES - 1));

   // Flipping the sign bit of both operands maps two's complement onto
   // offset binary, so the unsigned slice compare orders signed values.
   always_comb begin
      slice_a = a_q[int'(k_q)*BIT_COUNT +: BIT_COUNT];
      slice_b = b_q[int'(k_q)*BIT_COUNT +: BIT_COUNT];
      if (signed_q && top_slice) begin
         slice_a[BIT_COUNT-1] = ~slice_a[BIT_COUNT-1];
         slice_b[BIT_COUNT-1] = ~slice_b[BIT_COUNT-1];
      end
   end

   xor_comparator #(
      .BIT_COUNT (BIT_COUNT)
   ) u_cmp (
      .a_i          (slice_a),
      .b_i          (slice_b),
      .equal_o      (cmp_equal),
      .a_larger_o   (cmp_a_larger),
      .xor_result_o (cmp_xor)
   );

   // The first differing slice decides; later slices keep that decision.
   always_comb begin
      decided_nx = decided_q | ~cmp_equal;
      gt_nx      = decided_q ? gt_r_q : cmp_a_larger;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         a_q       <= '0;
         b_q       <= '0;
         signed_q  <= 1'b0;
         k_q       <= '0;
         decided_q <= 1'b0;
         gt_r_q    <= 1'b0;
         eq_q      <= 1'b0;
         gt_q      <= 1'b0;
         lt_q      <= 1'b0;
         xor_q     <= '0;
      end else begin
         case (state_q)
            StRun: begin
               // Inverting both sign bits leaves their XOR unchanged, so the
               // comparator output is already the raw a ^ b.
               xor_q[int'(k_q)*BIT_COUNT +: BIT_COUNT] <= cmp_xor;
               decided_q <= decided_nx;
               gt_r_q    <= gt_nx;
               if (k_q == '0) begin
                  state_q <= StDone;
                  eq_q    <= ~decided_nx;
                  gt_q    <= decided_nx & gt_nx;
                  lt_q    <= decided_nx & ~gt_nx;
               end else begin
                  k_q <= k_q - KW'(1);
               end
            end
            StDone: begin
               if (out_ready) state_q <= StIdle;
            end
            default: begin
               // Unknown encodings behave as IDLE.
               if (in_valid) begin
                  a_q       <= a;
                  b_q       <= b;
                  signed_q  <= is_signed;
                  decided_q <= 1'b0;
                  gt_r_q    <= 1'b0;
                  k_q       <= KW'(SLICES - 1);
                  state_q   <= StRun;
               end else begin
                  state_q <= StIdle;
               end
            end
         endcase
      end
   end

   assign in_ready   = (state_q != StRun) && (state_q != StDone);
   assign out_valid  = (state_q == StDone);
   assign eq         = eq_q;
   assign gt         = gt_q;
   assign lt         = lt_q;
   assign xor_result = xor_q;

endmodule

// File: tb/tb_wide_compare_seq.sv
module tb_wide_compare_seq;

   typedef struct packed {
      logic        eq;
      logic        gt;
      logic        lt;
      logic [31:0] x;
   } exp_t;

   typedef struct packed {
      logic       eq;
      logic       gt;
      logic       lt;
      logic [7:0] x;
   } exp8_t;

   logic clk, rst;

   // 32-bit instance (BIT_COUNT=8, SLICES=4)
   logic        in_valid, in_ready, is_signed, out_valid, out_ready;
   logic        eq, gt, lt;
   logic [31:0] a, b, xor_result;

   // 8-bit instance (SLICES=1)
   logic        in_valid1, in_ready1, is_signed1, out_valid1, out_ready1;
   logic        eq1, gt1, lt1;
   logic [7:0]  a1, b1, xor_result1;

   int   checks = 0;
   int   passes = 0;
   exp_t  q[$];
   exp8_t q1[$];

   wide_compare_seq #(.BIT_COUNT(8), .SLICES(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .is_signed  (is_signed),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .eq         (eq),
      .gt         (gt),
      .lt         (lt),
      .xor_result (xor_result)
   );

   wide_compare_seq #(.BIT_COUNT(8), .SLICES(1)) dut1 (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid1),
      .in_ready   (in_ready1),
      .a          (a1),
      .b          (b1),
      .is_signed  (is_signed1),
      .out_valid  (out_valid1),
      .out_ready  (out_ready1),
      .eq         (eq1),
      .gt         (gt1),
      .lt         (lt1),
      .xor_result (xor_result1)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks = checks + 1;
      assert (obs === exp) passes = passes + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv, input logic s);
      exp_t r;
      if (s) begin
         r.gt = $signed(av) > $signed(bv);
         r.lt = $signed(av) < $signed(bv);
      end else begin
         r.gt = av > bv;
         r.lt = av < bv;
      end
      r.eq = (av == bv);
      r.x  = av ^ bv;
      return r;
   endfunction

   function automatic exp8_t model8(input logic [7:0] av, input logic [7:0] bv, input logic s);
      exp8_t r;
      if (s) begin
         r.gt = $signed(av) > $signed(bv);
         r.lt = $signed(av) < $signed(bv);
      end else begin
         r.gt = av > bv;
         r.lt = av < bv;
      end
      r.eq = (av == bv);
      r.x  = av ^ bv;
      return r;
   endfunction

   // Entered and left at a negedge with the DUT in IDLE.
   task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input logic s,
                        input int hold, input bit pulse);
      exp_t e;
      int   n;
      q.push_back(model(av, bv, s));
      check("in_ready_idle", in_ready, 1);
      a = av; b = bv; is_signed = s; in_valid = 1;
      @(posedge clk);
      @(negedge clk);
      // Scramble inputs: the DUT must work from its latched copies.
      in_valid = 0; a = $urandom; b = $urandom; is_signed = ~s;
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
         if (pulse && n == 1) begin
            in_valid = 1; a = $urandom; b = $urandom;
         end else begin
            in_valid = 0;
         end
      end
      in_valid = 0;
      check("latency", n, 4);
      check("sb_nonempty", q.size() != 0, 1);
      if (q.size() != 0) begin
         e = q.pop_front();
         check("flags", {eq, gt, lt}, {e.eq, e.gt, e.lt});
         check("xor", xor_result, e.x);
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_flags", {eq, gt, lt}, {e.eq, e.gt, e.lt});
            check("hold_xor", xor_result, e.x);
         end
      end
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      check("idle_after_valid", out_valid, 0);
      check("idle_after_ready", in_ready, 1);
   endtask

   task automatic do_op1(input logic [7:0] av, input logic [7:0] bv, input logic s);
      exp8_t e;
      int    n;
      q1.push_back(model8(av, bv, s));
      check("s1_in_ready", in_ready1, 1);
      a1 = av; b1 = bv; is_signed1 = s; in_valid1 = 1;
      @(posedge clk);
      @(negedge clk);
      in_valid1 = 0; a1 = 8'h5a; b1 = 8'ha5;
      n = 0;
      while (!out_valid1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("s1_latency", n, 1);
      check("s1_sb_nonempty", q1.size() != 0, 1);
      if (q1.size() != 0) begin
         e = q1.pop_front();
         check("s1_flags", {eq1, gt1, lt1}, {e.eq, e.gt, e.lt});
         check("s1_xor", xor_result1, e.x);
      end
      out_ready1 = 1;
      @(negedge clk);
      out_ready1 = 0;
      check("s1_idle", {out_valid1, in_ready1}, 2'b01);
   endtask

   initial begin
      clk = 0; rst = 1;
      in_valid = 0; out_ready = 0; a = 0; b = 0; is_signed = 0;
      in_valid1 = 0; out_ready1 = 0; a1 = 0; b1 = 0; is_signed1 = 0;
      repeat (2) @(negedge clk);
      rst = 0;

      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_flags", {eq, gt, lt}, 3'b000);
      check("rst_xor", xor_result, 32'h0);
      check("rst_s1", {in_ready1, out_valid1, eq1, gt1, lt1}, 5'b10000);

      do_op(32'h1234_5678, 32'h1234_5678, 1'b0, 0, 0);
      do_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 0, 0);
      do_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 0, 0);
      do_op(32'h0000_0001, 32'h0000_0002, 1'b0, 0, 0);
      do_op(32'h0100_00FF, 32'h0000_0000, 1'b0, 0, 0);
      do_op(32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 3, 0);
      do_op(32'h0000_00F0, 32'h0000_000F, 1'b1, 0, 1);

      // Reset during the second RUN cycle aborts the operation.
      check("abort_in_ready", in_ready, 1);
      a = 32'hDEAD_BEEF; b = 32'h0000_0001; is_signed = 0; in_valid = 1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 0;
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      check("abort_out_valid", out_valid, 0);
      check("abort_in_ready_after", in_ready, 1);
      check("abort_flags", {eq, gt, lt}, 3'b000);
      check("abort_xor", xor_result, 32'h0);
      do_op(32'h7000_0000, 32'h7000_0001, 1'b1, 0, 0);

      for (int i = 0; i < 4; i++) begin
         do_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1, 0);
      end

      do_op1(8'hFF, 8'h01, 1'b1);
      do_op1(8'hFF, 8'h01, 1'b0);
      do_op1(8'h80, 8'h80, 1'b1);

      check("sb_drained", q.size() + q1.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
